// File: rtl/caliptra_apb_initiator.sv
// Single-outstanding APB initiator: turns cmd_* requests into SETUP/ACCESS transfers and returns rsp_*.
// Optional ACCESS-phase timeout enabled by defining CALIPTRA_APB_INIT_TIMEOUT_EN.
`ifndef CALIPTRA_APB_ADDR_WIDTH
`define CALIPTRA_APB_ADDR_WIDTH 32
`endif
`ifndef CALIPTRA_APB_DATA_WIDTH
`define CALIPTRA_APB_DATA_WIDTH 32
`endif
`ifndef CALIPTRA_APB_USER_WIDTH
`define CALIPTRA_APB_USER_WIDTH 32
`endif

module caliptra_apb_initiator #(
    parameter int ADDR_W         = `CALIPTRA_APB_ADDR_WIDTH,
    parameter int DATA_W         = `CALIPTRA_APB_DATA_WIDTH,
    parameter int USER_W         = `CALIPTRA_APB_USER_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [USER_W-1:0] cmd_user,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [USER_W-1:0] pauser,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [2:0]        pprot,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_cmd_hs;
    logic                w_rsp_hs;
    logic                w_done;
    logic                w_timeout;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [USER_W-1:0]   r_pauser;
    logic                r_pwrite;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_rsp_timeout;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_rsp_hs  = r_rsp_valid && rsp_ready;
    assign w_done    = (r_state == S_ACCESS) && pready;

`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_state == S_SETUP) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS && !pready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the number of stalled ACCESS cycles already elapsed
    assign w_timeout = (r_state == S_ACCESS) && !pready &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        psel        = 1'b0;
        penable     = 1'b0;
        case (r_state)
            S_IDLE:   if (w_cmd_hs) w_state_nxt = S_SETUP;
            S_SETUP: begin
                psel        = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || w_timeout) w_state_nxt = S_RESP;
            end
            S_RESP:   if (w_rsp_hs) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pauser <= '0;
            r_pwrite <= 1'b0;
        end else if (w_cmd_hs) begin
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
            r_pauser <= cmd_user;
            r_pwrite <= cmd_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_err     <= pslverr;
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end else if (w_rsp_hs) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pauser      = r_pauser;
    assign pwrite      = r_pwrite;
    assign pprot       = 3'b000;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_caliptra_apb_initiator.sv
// Directed bench for caliptra_apb_initiator; expected responses are queued at issue and popped on rsp_valid.
// Covers the CALIPTRA_APB_INIT_TIMEOUT_EN build when that macro is defined for the bench as well.
module tb_caliptra_apb_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] cmd_user = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] pauser;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [2:0]  pprot;
    logic [31:0] prdata = '0;
    logic        pready = 1'b1;
    logic        pslverr = 1'b0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    caliptra_apb_initiator #(
        .ADDR_W(32),
        .DATA_W(32),
        .USER_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_user(cmd_user),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwdata(pwdata), .pauser(pauser), .pwrite(pwrite),
        .psel(psel), .penable(penable), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Returns one cycle after the accepting edge (first SETUP cycle).
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [31:0] u);
        int i;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_user = u; cmd_valid = 1'b1;
        #1;
        i = 0;
        while (!cmd_ready && i < 100) begin tick(); i++; end
        chk("issue_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input bit consume, output int cyc);
        exp_t e;
        int   i;
        i = 0;
        while (!rsp_valid && i < 2000) begin tick(); i++; end
        cyc = i;
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, rsp_err, e.err);
        chk({tag, "_timeout"}, rsp_timeout, e.to);
        if (consume) begin
            rsp_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] held_rdata;
        logic        held_err;

        // Reset
        repeat (3) tick();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd_ready_in_rst", cmd_ready, 0);
        chk("rst_pprot", pprot, 0);
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready_after", cmd_ready, 1);

        // Zero-wait write
        prdata = 32'hFFFF_0000;
        pready = 1'b1;
        issue(1'b1, 32'h3000_0040, 32'hDEAD_BEEF, 32'h5);
        sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        chk("wr_t1_psel", psel, 1);
        chk("wr_t1_penable", penable, 0);
        chk("wr_t1_paddr", paddr, 32'h3000_0040);
        chk("wr_t1_pwdata", pwdata, 32'hDEAD_BEEF);
        chk("wr_t1_pwrite", pwrite, 1);
        chk("wr_t1_pauser", pauser, 32'h5);
        chk("wr_t1_cmd_ready", cmd_ready, 0);
        tick();
        chk("wr_t2_psel", psel, 1);
        chk("wr_t2_penable", penable, 1);
        chk("wr_t2_paddr", paddr, 32'h3000_0040);
        chk("wr_t2_pwdata", pwdata, 32'hDEAD_BEEF);
        collect("wr", 1'b0, cyc);
        chk("wr_latency", cyc, 1);
        chk("wr_t3_psel", psel, 0);
        chk("wr_t3_penable", penable, 0);
        tick();
        chk("wr_t4_rsp_valid", rsp_valid, 0);
        chk("wr_t4_cmd_ready", cmd_ready, 1);

        // Read with three wait states
        pready = 1'b0;
        prdata = 32'h1234_5678;
        issue(1'b0, 32'h3003_0000, 32'h0, 32'h0);
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, to: 1'b0});
        repeat (3) tick();
        chk("rdw_t4_penable", penable, 1);
        chk("rdw_t4_pwrite", pwrite, 0);
        tick();
        chk("rdw_t5_rsp_valid", rsp_valid, 0);
        pready = 1'b1;
        collect("rdw", 1'b1, cyc);
        chk("rdw_latency", cyc, 1);

        // Back-to-back commands with stalled response
        rsp_ready = 1'b0;
        prdata = 32'h0BAD_F00D;
        issue(1'b1, 32'h3000_0100, 32'h1111_2222, 32'h7);
        sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        cmd_write = 1'b0; cmd_addr = 32'h3000_0200; cmd_wdata = 32'h0; cmd_user = 32'h9;
        cmd_valid = 1'b1;
        collect("b2b_a", 1'b0, cyc);
        held_rdata = rsp_rdata;
        held_err   = rsp_err;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("b2b_hold_valid", rsp_valid, 1);
            chk("b2b_hold_rdata", rsp_rdata, held_rdata);
            chk("b2b_hold_err", rsp_err, held_err);
            chk("b2b_hold_cmd_ready", cmd_ready, 0);
            chk("b2b_hold_psel", psel, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("b2b_hs_rsp_valid", rsp_valid, 0);
        chk("b2b_hs_cmd_ready", cmd_ready, 1);
        chk("b2b_hs_psel", psel, 0);
        tick();
        cmd_valid = 1'b0;
        sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, to: 1'b0});
        chk("b2b_setup_psel", psel, 1);
        chk("b2b_setup_penable", penable, 0);
        chk("b2b_setup_paddr", paddr, 32'h3000_0200);
        chk("b2b_setup_pauser", pauser, 32'h9);
        tick();
        collect("b2b_b", 1'b1, cyc);
        chk("b2b_b_latency", cyc, 1);

        // Slave error on read still returns data
        pslverr = 1'b1;
        prdata  = 32'hA5A5_A5A5;
        issue(1'b0, 32'h3000_0300, 32'h0, 32'h0);
        sb.push_back('{rdata: 32'hA5A5_A5A5, err: 1'b1, to: 1'b0});
        collect("slverr", 1'b1, cyc);
        chk("slverr_latency", cyc, 2);
        pslverr = 1'b0;

        // Pready held low
        pready = 1'b0;
        prdata = 32'h5555_AAAA;
        issue(1'b0, 32'h3000_0400, 32'h0, 32'h0);
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
        sb.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
        collect("tmo", 1'b0, cyc);
        chk("tmo_latency", cyc, 5);
        chk("tmo_psel", psel, 0);
        chk("tmo_penable", penable, 0);
        tick();
`else
        repeat (1000) tick();
        chk("stuck_psel", psel, 1);
        chk("stuck_penable", penable, 1);
        chk("stuck_rsp_valid", rsp_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
`endif
        chk("after_stall_cmd_ready", cmd_ready, 1);

        // Reset during second ACCESS cycle
        pready = 1'b0;
        issue(1'b0, 32'h3000_0500, 32'h0, 32'h0);
        tick();
        tick();
        chk("rstmid_pre_penable", penable, 1);
        rst = 1'b1;
        tick();
        chk("rstmid_psel", psel, 0);
        chk("rstmid_penable", penable, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_cmd_ready_in_rst", cmd_ready, 0);
        rst = 1'b0;
        pready = 1'b1;
        #1;
        chk("rstmid_cmd_ready", cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstmid_no_rsp", rsp_valid, 0);
        end

        // Recovery write
        issue(1'b1, 32'h3000_0600, 32'hCAFE_F00D, 32'h1);
        sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        chk("rec_pwdata", pwdata, 32'hCAFE_F00D);
        collect("rec", 1'b1, cyc);
        chk("rec_latency", cyc, 2);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/caliptra_apb_initiator.md
# caliptra_apb_initiator

APB initiator that turns single-word read/write commands into APB transfers toward the Caliptra APB responder, i.e. the SoC side of `PADDR/PSEL/PENABLE/PWRITE/PWDATA/PAUSER/PRDATA/PREADY/PSLVERR`. It is used in the verilated and FPGA harnesses so that sequencers, such as mailbox drivers, can issue register accesses without hand-toggling APB phases. Each transfer returns a response carrying read data, a slave-error flag and an optional timeout flag.

## Interface
- `ADDR_W`, default `CALIPTRA_APB_ADDR_WIDTH`: APB address width.
- `DATA_W`, default `CALIPTRA_APB_DATA_WIDTH`: APB data width.
- `USER_W`, default `CALIPTRA_APB_USER_WIDTH`: PAUSER width.
- `TIMEOUT_CYCLES`, default 256: maximum ACCESS-phase length, min 2. Used only with the configuration macro.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  target address.
- `cmd_wdata`  in  DATA_W  write data.
- `cmd_user`  in  USER_W  PAUSER value.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and timeouts.
- `rsp_err`  out  1  PSLVERR or timeout.
- `rsp_timeout`  out  1  transfer aborted by timeout.
- `paddr`, `pwdata`, `pauser`, `pwrite`, `psel`, `penable`, `pprot[2:0]`  out  APB request signals. `pprot` is tied to 0.
- `prdata`, `pready`, `pslverr`  in  APB response signals.

## Operation
- FSM states and transitions:
  - IDLE → SETUP on a command handshake.
  - SETUP → ACCESS unconditionally.
  - ACCESS → RESP when `pready` = 1, or on timeout.
  - RESP → IDLE on the `rsp_valid && rsp_ready` handshake.
- `cmd_ready` = (state == IDLE) && !rst. It is combinational from state and never depends on `cmd_valid`.
- Command capture at the handshake edge:
  - `cmd_*` fields are registered into `paddr/pwdata/pwrite/pauser`.
  - These stay stable through SETUP and ACCESS.
  - They then hold their last value until the next command.
- APB phase signals:
  - SETUP: `psel`=1, `penable`=0.
  - ACCESS: `psel`=1, `penable`=1.
  - IDLE and RESP: both 0.
- Completion sampling:
  - `pready` and `pslverr` are sampled only in ACCESS; `pready` in SETUP is ignored.
  - On completion `rsp_err` ← `pslverr` and `rsp_timeout` ← 0.
  - `rsp_rdata` ← `prdata` for reads, 0 for writes.
  - Read data is captured even when `pslverr` = 1.
- Response outputs hold stable while `rsp_valid`=1 and `rsp_ready`=0. Only one transfer is outstanding at a time.
- Reset values: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pauser`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout` all 0. State = IDLE.
- Reset mid-transfer (any state): at the next edge the FSM goes to IDLE and `psel`/`penable` drop. Any in-flight or pending response is discarded with no `rsp_valid` pulse.

## Timing
- Zero-wait transfer:
  - Command accepted at edge T.
  - `psel` high from T+1 (SETUP); `penable` high from T+2 (ACCESS).
  - `pready`=1 during T+2, so `psel`/`penable` are 0 and `rsp_valid`=1 from T+3.
- Each cycle of `pready`=0 in ACCESS adds one cycle.
- With `rsp_ready` held high:
  - The response handshake occurs in the first RESP cycle.
  - `cmd_ready` rises the next cycle.
  - Throughput is one transfer per 4 cycles.
- `cmd_ready` is 0 from SETUP through RESP. A `cmd_valid` asserted in those states waits; it is not dropped.

## Configuration
- Macro: `CALIPTRA_APB_INIT_TIMEOUT_EN`.
- Defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES)+1` clears on SETUP and increments each ACCESS cycle with `pready`=0.
  - When ACCESS has lasted `TIMEOUT_CYCLES` cycles with `pready`=0, the FSM moves to RESP. That makes `psel`/`penable` 0 at cycle T+2+`TIMEOUT_CYCLES`.
  - Timeout response: `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - A `pready`=1 in the final counted cycle wins over the timeout, giving a normal completion.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - `rsp_timeout` is tied 0.

## Test plan
- Write 0x3000_0040 ← 0xDEAD_BEEF, `pready`=1 immediately → `psel`/`penable` at T+1/T+2 with stable address/data; `rsp_valid` at T+3 with `rsp_err`=0, `rsp_rdata`=0.
- Read 0x3003_0000, `pready` low for 3 ACCESS cycles, `prdata`=0x1234_5678 → `rsp_valid` at T+6 with `rsp_rdata`=0x1234_5678.
- Two commands queued back-to-back, `rsp_ready` low for 5 cycles → first response held unchanged; second SETUP starts exactly 1 cycle after the first response handshake.
- Read with `pslverr`=1, `prdata`=0xA5A5_A5A5 → `rsp_err`=1, `rsp_rdata`=0xA5A5_A5A5, `rsp_timeout`=0.
- With the macro and `TIMEOUT_CYCLES`=4, `pready` held 0 → bus released at T+6, `rsp_err`=`rsp_timeout`=1. Without the macro, same stimulus → still in ACCESS after 1000 cycles.
- `rst` asserted for one cycle in the second ACCESS cycle → `psel`=0 next cycle, no `rsp_valid`, `cmd_ready`=1 after `rst` deasserts.
